// File: rtl/bcd_scan_controller.sv
`timescale 1ns/1ps
// bcd_scan_controller
// Multiplexed driver for a three-digit, common-anode seven-segment display.
// A loaded BCD value is held in a shadow register and only moves to the
// scanned display register at a frame boundary. This keeps a digit from
// changing part-way through a scan. Each digit is lit for REFRESH_DIV
// cycles, and BLANK_CYC dark cycles separate consecutive digits to avoid
// ghosting.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : display enable (0 = all digits dark, scan held at start)
//   load       : one-cycle strobe capturing bcd_in into the shadow register
//   bcd_in     : [11:8] digit2 (MS), [7:4] digit1, [3:0] digit0 (LS)
//   seg        : shared segments, active low, gfedcba (registered)
//   an         : digit enables, active low, an[k] = digit k (registered)
//   frame_done : high during the last cycle of SHOW(digit2)
//   pending    : a loaded value is waiting for the next frame boundary
module bcd_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int LZ_BLANK    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [11:0] bcd_in,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = 20;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit            SKIP_BLANK = (BLANK_CYC == 0);
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t        state, state_next;
    logic [1:0]    d, d_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          run, run_next;       // 0 until the first dwell after reset / en rise
    logic [11:0]   shadow, display, display_next;
    logic          pending_next;
    logic          transfer;
    logic [3:0]    digit;
    logic          lz;
    logic [6:0]    seg_next;
    logic [2:0]    an_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        d_next     = d;
        cnt_next   = cnt + 1'b1;
        run_next   = run;
        transfer   = 1'b0;

        if (!en) begin
            // Parked at BLANK(d0); display tracks shadow continuously.
            state_next = BLANK;
            d_next     = 2'd0;
            cnt_next   = '0;
            run_next   = 1'b0;
            transfer   = 1'b1;
        end else if (!run) begin
            // First edge after reset release or en rise: enter BLANK(d0).
            run_next   = 1'b1;
            d_next     = 2'd0;
            cnt_next   = '0;
            transfer   = 1'b1;
            state_next = SKIP_BLANK ? SHOW : BLANK;
        end else if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_next = SHOW;
                cnt_next   = '0;
            end
        end else if (cnt == SHOW_LAST) begin
            cnt_next   = '0;
            d_next     = (d == 2'd2) ? 2'd0 : d + 2'd1;
            state_next = SKIP_BLANK ? SHOW : BLANK;
            transfer   = (d == 2'd2);   // frame boundary
        end

        display_next = transfer ? shadow : display;

        // A load on a transfer edge wins, so pending stays set.
        if (!en)           pending_next = 1'b0;
        else if (load)     pending_next = 1'b1;
        else if (transfer) pending_next = 1'b0;
        else               pending_next = pending;

        case (d_next)
            2'd1:    digit = display_next[7:4];
            2'd2:    digit = display_next[11:8];
            default: digit = display_next[3:0];
        endcase

        lz = (LZ_BLANK != 0) &&
             (((d_next == 2'd2) && (display_next[11:8] == 4'd0)) ||
              ((d_next == 2'd1) && (display_next[11:4] == 8'd0)));

        // Outputs are computed from the next state so they change on the
        // same edge as the state itself.
        an_next  = 3'b111;
        seg_next = SEG_OFF;
        if (state_next == SHOW) begin
            an_next  = ~(3'b001 << d_next);
            seg_next = lz ? SEG_OFF : decode(digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BLANK;
            d       <= 2'd0;
            cnt     <= '0;
            run     <= 1'b0;
            shadow  <= 12'h000;
            display <= 12'h000;
            pending <= 1'b0;
            seg     <= SEG_OFF;
            an      <= 3'b111;
        end else begin
            state   <= state_next;
            d       <= d_next;
            cnt     <= cnt_next;
            run     <= run_next;
            if (load) shadow <= bcd_in;
            display <= display_next;
            pending <= pending_next;
            seg     <= seg_next;
            an      <= an_next;
        end
    end

    assign frame_done = run && en && (state == SHOW) && (d == 2'd2) && (cnt == SHOW_LAST);

endmodule

// File: tb/tb_bcd_scan_controller.sv
`timescale 1ns/1ps
// Directed testbench for bcd_scan_controller (REFRESH_DIV=4, BLANK_CYC=1).
// Two instances share the inputs: one with leading-zero suppression and one
// without.
module tb_bcd_scan_controller;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                           BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic [6:0]  seg, seg_z;
    logic [2:0]  an, an_z;
    logic        frame_done, fd_z, pending, pend_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_scan_controller #(.REFRESH_DIV(4), .BLANK_CYC(1), .LZ_BLANK(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
        .seg(seg), .an(an), .frame_done(frame_done), .pending(pending));

    bcd_scan_controller #(.REFRESH_DIV(4), .BLANK_CYC(1), .LZ_BLANK(0)) dut_z (
        .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
        .seg(seg_z), .an(an_z), .frame_done(fd_z), .pending(pend_z));

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".an"},  12'(an), 12'h7);
        chk({tag, ".seg"}, 12'(seg), 12'(BL));
        chk({tag, ".fd"},  12'(frame_done), 12'h0);
        chk({tag, ".pend"}, 12'(pending), 12'h0);
        chk({tag, ".an_z"}, 12'(an_z), 12'h7);
        chk({tag, ".pend_z"}, 12'(pend_z), 12'h0);
    endtask

    // Entered just after the edge that starts BLANK(d0); leaves just after
    // the edge that starts the next BLANK(d0). Frame schedule for k=0..14:
    // 0 blank, 1-4 digit0, 5 blank, 6-9 digit1, 10 blank, 11-14 digit2.
    task automatic run_frame(input string tag,
                             input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                             input logic [6:0] z0, input logic [6:0] z1, input logic [6:0] z2,
                             input logic pend0, input int load_k, input logic [11:0] val);
        logic [2:0] ex_an;
        logic [6:0] ex_seg, ex_z;
        logic       ex_p;
        for (int k = 0; k < 15; k++) begin
            if (k == 0 || k == 5 || k == 10) begin
                ex_an = 3'b111; ex_seg = BL; ex_z = BL;
            end else if (k < 5) begin
                ex_an = 3'b110; ex_seg = a0; ex_z = z0;
            end else if (k < 10) begin
                ex_an = 3'b101; ex_seg = a1; ex_z = z1;
            end else begin
                ex_an = 3'b011; ex_seg = a2; ex_z = z2;
            end
            ex_p = (load_k >= 0 && k > load_k) ? 1'b1 : pend0;
            chk($sformatf("%s.k%0d.an", tag, k),    12'(an),         12'(ex_an));
            chk($sformatf("%s.k%0d.seg", tag, k),   12'(seg),        12'(ex_seg));
            chk($sformatf("%s.k%0d.fd", tag, k),    12'(frame_done), 12'(k == 14));
            chk($sformatf("%s.k%0d.pend", tag, k),  12'(pending),    12'(ex_p));
            chk($sformatf("%s.k%0d.seg_z", tag, k), 12'(seg_z),      12'(ex_z));
            chk($sformatf("%s.k%0d.an_z", tag, k),  12'(an_z),       12'(ex_an));
            if (k == load_k) begin
                load = 1'b1;
                bcd_in = val;
            end
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        // Reset
        #1 rst = 1'b1;
        #1 chk_dark("reset");
        step();
        step();
        chk_dark("reset_held");
        rst = 1'b0;

        // Load 123 while disabled; display follows shadow, pending stays 0
        load = 1'b1; bcd_in = 12'h123;
        step();
        load = 1'b0;
        chk_dark("en0_load");
        step();
        en = 1'b1;
        step();

        run_frame("f1_123", S3, S2, S1, S3, S2, S1, 1'b0, -1, 12'h000);
        run_frame("f2_123", S3, S2, S1, S3, S2, S1, 1'b0, -1, 12'h000);
        run_frame("f3_ld007", S3, S2, S1, S3, S2, S1, 1'b0, 0, 12'h007);
        run_frame("f4_007", S7, BL, BL, S7, S0, S0, 1'b0, 7, 12'h456);
        run_frame("f5_456", S6, S5, S4, S6, S5, S4, 1'b0, 14, 12'h080);
        run_frame("f6_456", S6, S5, S4, S6, S5, S4, 1'b1, 1, 12'h999);
        run_frame("f7_999", S9, S9, S9, S9, S9, S9, 1'b0, 3, 12'hAB5);

        // AB5 frame cut short by reset in the last SHOW(d2) cycle
        for (int i = 0; i < 14; i++) begin
            if (i == 1)  chk("f8.k1.seg",  12'(seg), 12'(S5));
            if (i == 6)  chk("f8.k6.seg",  12'(seg), 12'(BL));
            if (i == 6)  chk("f8.k6.an",   12'(an),  12'h5);
            step();
        end
        chk("f8.k14.an", 12'(an), 12'h3);
        chk("f8.k14.fd", 12'(frame_done), 12'h1);
        #2 rst = 1'b1;
        #1 chk_dark("async_rst");
        load = 1'b1; bcd_in = 12'h321;
        step();
        chk_dark("rst_over_load");
        rst = 1'b0;
        load = 1'b0;
        step();
        run_frame("f9_rst", S0, BL, BL, S0, S0, S0, 1'b0, -1, 12'h000);

        // Drop en in SHOW(d1)
        for (int i = 0; i < 7; i++) step();
        chk("f10.k7.an", 12'(an), 12'h5);
        en = 1'b0;
        load = 1'b1; bcd_in = 12'h042;
        step();
        load = 1'b0;
        chk_dark("en_drop");
        step();
        chk_dark("en_low");
        en = 1'b1;
        step();
        run_frame("f11_042", S2, S4, BL, S2, S4, S0, 1'b0, -1, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
